// File: rtl/vx_evict_wb_queue_if.sv
// Writeback queue handshake bundle.
//   evict_*   : bank pipe -> queue (dirty line capture, valid/ready)
//   mem_req_* : queue -> memory write port (valid/ready)
// slave  : the queue side (accepts evictions, issues memory writes)
// master : the environment side (bank pipe plus memory port)
interface vx_evict_wb_queue_if #(
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int BANK_LINE_WORDS = 4,
  parameter int WORD_SIZE       = 4
);
  localparam int LINE_BYTES = BANK_LINE_WORDS * WORD_SIZE;
  localparam int LINE_WIDTH = LINE_BYTES * 8;

  logic                       evict_valid;
  logic [LINE_ADDR_WIDTH-1:0] evict_addr;
  logic [LINE_WIDTH-1:0]      evict_data;
  logic [LINE_BYTES-1:0]      evict_byteen;
  logic                       evict_ready;

  logic                       mem_req_valid;
  logic [LINE_ADDR_WIDTH-1:0] mem_req_addr;
  logic [LINE_WIDTH-1:0]      mem_req_data;
  logic [LINE_BYTES-1:0]      mem_req_byteen;
  logic                       mem_req_ready;

  modport master (
    output evict_valid, evict_addr, evict_data, evict_byteen,
    input  evict_ready,
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_byteen,
    output mem_req_ready
  );

  modport slave (
    input  evict_valid, evict_addr, evict_data, evict_byteen,
    output evict_ready,
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_byteen,
    input  mem_req_ready
  );
endinterface

// File: rtl/vx_evict_wb_queue.sv
// Dirty-line writeback queue sitting below the bank tag/data store.
// Captures evicted dirty lines (address, data, byte mask), drains them in
// order to the memory write port, and offers a combinational snoop so the
// bank can hold off a refill/miss to a line still waiting for writeback.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   wb_if        : evict_* capture handshake and mem_req_* drain handshake
//   snoop_addr   : line address probed by the bank pipe
//   snoop_hit    : probed line is pending in the queue
//   count        : occupied entries; full/empty derived from it
// The interface instance must carry the same LINE_ADDR_WIDTH,
// BANK_LINE_WORDS and WORD_SIZE as this module.
module vx_evict_wb_queue #(
  parameter int NUM_ENTRIES     = 4,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int BANK_LINE_WORDS = 4,
  parameter int WORD_SIZE       = 4,
  localparam int LINE_BYTES     = BANK_LINE_WORDS * WORD_SIZE,
  localparam int LINE_WIDTH     = LINE_BYTES * 8,
  localparam int PTR_W          = $clog2(NUM_ENTRIES),
  localparam int CNT_W          = PTR_W + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  vx_evict_wb_queue_if.slave         wb_if,
  input  logic [LINE_ADDR_WIDTH-1:0] snoop_addr,
  output logic                       snoop_hit,
  output logic [CNT_W-1:0]           count,
  output logic                       full,
  output logic                       empty
);

  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;

  logic [LINE_ADDR_WIDTH-1:0] addr_q   [NUM_ENTRIES];
  logic [LINE_WIDTH-1:0]      data_q   [NUM_ENTRIES];
  logic [LINE_BYTES-1:0]      byteen_q [NUM_ENTRIES];

  logic enq, deq;

  assign full  = (count_q == CNT_W'(NUM_ENTRIES));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Ready looks only at registered occupancy: a drain in the same cycle
  // never opens a slot for a simultaneous capture when full.
  assign wb_if.evict_ready = ~full;

  // Clean lines (no dirty bytes) are acknowledged but never stored.
  assign enq = wb_if.evict_valid && !full && (|wb_if.evict_byteen);
  assign deq = !empty && wb_if.mem_req_ready;

  assign wb_if.mem_req_valid  = ~empty;
  assign wb_if.mem_req_addr   = addr_q[head_q];
  assign wb_if.mem_req_data   = data_q[head_q];
  assign wb_if.mem_req_byteen = byteen_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (enq) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    // Head and tail never coincide when both fire (not full, not empty),
    // so this clear cannot undo the set above.
    if (deq) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Snoop covers the head entry even while it is being handed to memory.
  always_comb begin
    snoop_hit = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && (addr_q[i] == snoop_addr)) snoop_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Line storage carries no reset; per-entry valid bits gate every use.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q]   <= wb_if.evict_addr;
      data_q[tail_q]   <= wb_if.evict_data;
      byteen_q[tail_q] <= wb_if.evict_byteen;
    end
  end

endmodule

// File: tb/tb_vx_evict_wb_queue.sv
// Bench for vx_evict_wb_queue: directed scenarios followed by random traffic,
// all compared every cycle against an ordered-list model of pending lines.
module tb_vx_evict_wb_queue;
  localparam int N   = 4;
  localparam int LAW = 26;
  localparam int BLW = 4;
  localparam int WS  = 4;
  localparam int LB  = BLW * WS;
  localparam int LW  = LB * 8;
  localparam int CW  = $clog2(N) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_evict_wb_queue_if #(.LINE_ADDR_WIDTH(LAW), .BANK_LINE_WORDS(BLW), .WORD_SIZE(WS)) wb_if ();

  logic [LAW-1:0] snoop_addr;
  logic           snoop_hit;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;

  vx_evict_wb_queue #(
    .NUM_ENTRIES(N), .LINE_ADDR_WIDTH(LAW), .BANK_LINE_WORDS(BLW), .WORD_SIZE(WS)
  ) dut (
    .clk(clk), .reset(reset), .wb_if(wb_if), .snoop_addr(snoop_addr),
    .snoop_hit(snoop_hit), .count(count), .full(full), .empty(empty)
  );

  typedef struct packed {
    logic [LAW-1:0] a;
    logic [LW-1:0]  d;
    logic [LB-1:0]  be;
  } ent_t;

  ent_t mq[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock: drive, check outputs against the model, clock, advance model.
  task automatic cyc(input logic rst, input logic ev_v, input logic [LAW-1:0] a,
                     input logic [LW-1:0] d, input logic [LB-1:0] be,
                     input logic rdy, input logic [LAW-1:0] sa);
    logic hit, enq, deq;
    ent_t e;
    reset = rst;
    wb_if.evict_valid  = ev_v;
    wb_if.evict_addr   = a;
    wb_if.evict_data   = d;
    wb_if.evict_byteen = be;
    wb_if.mem_req_ready = rdy;
    snoop_addr = sa;
    #1;
    hit = 1'b0;
    foreach (mq[i]) if (mq[i].a == sa) hit = 1'b1;
    chk("evict_ready", LW'(wb_if.evict_ready), LW'(mq.size() < N));
    chk("mem_req_valid", LW'(wb_if.mem_req_valid), LW'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("mem_req_addr", LW'(wb_if.mem_req_addr), LW'(mq[0].a));
      chk("mem_req_data", wb_if.mem_req_data, mq[0].d);
      chk("mem_req_byteen", LW'(wb_if.mem_req_byteen), LW'(mq[0].be));
    end
    chk("snoop_hit", LW'(snoop_hit), LW'(hit));
    chk("count", LW'(count), LW'(mq.size()));
    chk("full", LW'(full), LW'(mq.size() == N));
    chk("empty", LW'(empty), LW'(mq.size() == 0));
    enq = ev_v && (mq.size() < N) && (be != '0);
    deq = (mq.size() != 0) && rdy;
    @(posedge clk);
    #1;
    if (rst) mq.delete();
    else begin
      if (deq) void'(mq.pop_front());
      if (enq) begin
        e.a = a; e.d = d; e.be = be;
        mq.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic rdy, input logic [LAW-1:0] sa);
    cyc(1'b0, 1'b0, '0, '0, '0, rdy, sa);
  endtask

  task automatic push(input logic [LAW-1:0] a, input logic [LB-1:0] be,
                      input logic rdy, input logic [LAW-1:0] sa);
    cyc(1'b0, 1'b1, a, rnd_line(), be, rdy, sa);
  endtask

  initial begin
    logic [LW-1:0] dd;
    reset = 1'b1;
    wb_if.evict_valid = 1'b0; wb_if.evict_addr = '0; wb_if.evict_data = '0;
    wb_if.evict_byteen = '0; wb_if.mem_req_ready = 1'b0; snoop_addr = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state, then single capture held for five cycles, then drain.
    idle(1'b0, '0);
    push(26'h100, 16'hFFFF, 1'b0, 26'h100);
    chk("first_count", LW'(count), LW'(1));
    chk("first_addr", LW'(wb_if.mem_req_addr), LW'(26'h100));
    repeat (5) idle(1'b0, 26'h100);
    idle(1'b1, 26'h100);
    chk("drained_empty", LW'(empty), LW'(1));
    idle(1'b0, '0);

    // Fill, reject a fifth, drain in order, wrap.
    for (int i = 0; i < 4; i++) push(26'h10 + i, 16'hFFFF, 1'b0, 26'h12);
    chk("fill_full", LW'(full), LW'(1));
    chk("fill_ready", LW'(wb_if.evict_ready), LW'(0));
    push(26'h77, 16'hFFFF, 1'b0, 26'h77);
    chk("fifth_count", LW'(count), LW'(4));
    repeat (4) idle(1'b1, 26'h13);
    push(26'h14, 16'h00FF, 1'b0, 26'h14);
    push(26'h15, 16'hFF00, 1'b0, 26'h15);
    repeat (3) idle(1'b1, 26'h15);

    // Simultaneous capture and drain: at full, then at two.
    for (int i = 0; i < 4; i++) push(26'h40 + i, 16'hFFFF, 1'b0, 26'h50);
    push(26'h50, 16'hFFFF, 1'b1, 26'h50);
    chk("full_both_count", LW'(count), LW'(3));
    idle(1'b1, 26'h50);
    push(26'h51, 16'hFFFF, 1'b1, 26'h51);
    chk("two_both_count", LW'(count), LW'(2));
    repeat (3) idle(1'b1, 26'h51);

    // Clean drop.
    cyc(1'b0, 1'b1, 26'h20, rnd_line(), '0, 1'b0, 26'h20);
    idle(1'b0, 26'h20);
    chk("clean_count", LW'(count), LW'(0));
    chk("clean_snoop", LW'(snoop_hit), LW'(0));

    // Snoop timing around capture and drain, with a neighbour probe.
    push(26'h30, 16'hFFFF, 1'b0, 26'h30);
    for (int i = 0; i < 4; i++) idle(1'b0, (i % 2) ? 26'h31 : 26'h30);
    idle(1'b1, 26'h30);
    idle(1'b0, 26'h30);
    chk("snoop_cleared", LW'(snoop_hit), LW'(0));

    // Partial mask, then reset with three pending.
    dd = rnd_line();
    dd[31:0] = 32'hDEADBEEF;
    cyc(1'b0, 1'b1, 26'h200, dd, 16'h000F, 1'b0, 26'h200);
    chk("partial_be", LW'(wb_if.mem_req_byteen), LW'(16'h000F));
    chk("partial_word", LW'(wb_if.mem_req_data[31:0]), LW'(32'hDEADBEEF));
    idle(1'b1, 26'h200);
    for (int i = 0; i < 3; i++) push(26'h60 + i, 16'hF0F0, 1'b0, 26'h61);
    cyc(1'b1, 1'b0, '0, '0, '0, 1'b1, 26'h60);
    chk("reset_count", LW'(count), LW'(0));
    chk("reset_valid", LW'(wb_if.mem_req_valid), LW'(0));
    for (int i = 0; i < 3; i++) idle(1'b0, 26'h60 + i);

    // Random traffic over a small address pool so duplicates and hits occur.
    for (int n = 0; n < 3000; n++) begin
      logic [LB-1:0] be;
      be = ($urandom_range(0, 3) == 0) ? '0 : LB'($urandom);
      cyc(($urandom_range(0, 249) == 0),
          ($urandom_range(0, 2) != 0),
          LAW'(26'h80 + $urandom_range(0, 5)),
          rnd_line(), be,
          ($urandom_range(0, 2) == 0),
          LAW'(26'h80 + $urandom_range(0, 6)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/vx_evict_wb_queue.md
Name: vx_evict_wb_queue

Overview:
- Writeback buffer directly downstream of the bank tag/data store.
- When the bank pipe evicts a dirty line, it captures the line: address ({tag, line select}), full line data and per-byte dirty mask.
- Drains captured lines in order to the memory write port via a valid/ready handshake.
- Provides a combinational snoop so the bank can stall a refill or miss to a line still pending writeback.

Parameters:
- NUM_ENTRIES, 4, queue depth; power of two, at least 2.
- LINE_ADDR_WIDTH, 26, width of the line address ({tag, line select}).
- BANK_LINE_WORDS, 4, words per bank line.
- WORD_SIZE, 4, bytes per word.
- Derived: LINE_BYTES = BANK_LINE_WORDS*WORD_SIZE; LINE_WIDTH = LINE_BYTES*8; CNT_W = log2(NUM_ENTRIES)+1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- evict_valid  in  1  eviction request from the bank pipe.
- evict_addr  in  LINE_ADDR_WIDTH  evicted line address.
- evict_data  in  LINE_WIDTH  evicted line data.
- evict_byteen  in  LINE_BYTES  per-byte dirty mask of the evicted line.
- evict_ready  out  1  queue can accept an eviction this cycle.
- mem_req_valid  out  1  write request to memory.
- mem_req_addr  out  LINE_ADDR_WIDTH  head entry address.
- mem_req_data  out  LINE_WIDTH  head entry data.
- mem_req_byteen  out  LINE_BYTES  head entry byte enables.
- mem_req_ready  in  1  memory accepts the write.
- snoop_addr  in  LINE_ADDR_WIDTH  line address probed by the bank pipe.
- snoop_hit  out  1  probed line is pending in the queue.
- count  out  CNT_W  number of occupied entries.
- full  out  1  count == NUM_ENTRIES.
- empty  out  1  count == 0.

Behaviour:
- Storage is circular: head pointer, tail pointer, count register, and a per-entry valid bit. Pointers wrap modulo NUM_ENTRIES.
- Reset:
  - head = tail = count = 0; all valid bits cleared.
  - mem_req_valid = 0, snoop_hit = 0, empty = 1, full = 0, evict_ready = 1.
  - Data and address arrays are not reset.
- Ready: evict_ready = !full. It is combinational from registered state and does not depend on mem_req_ready. A dequeue in the same cycle does not free a slot for an enqueue when full.
- Enqueue:
  - An enqueue occurs on evict_valid && evict_ready && (|evict_byteen).
  - The entry is written at tail, tail increments, and the valid bit is set.
- Clean drop: evict_valid && evict_ready with evict_byteen == 0 is accepted but not stored. No state change.
- Dequeue:
  - mem_req_valid = !empty. mem_req_addr, mem_req_data and mem_req_byteen are driven from the head entry.
  - A dequeue occurs on mem_req_valid && mem_req_ready: head entry valid bit cleared, head increments.
- Output stability: while mem_req_valid && !mem_req_ready, all mem_req_* outputs hold stable.
- Latency:
  - An entry enqueued on edge T is visible on mem_req_* and in snoop_hit from cycle T+1.
  - An entry dequeued on edge T stops asserting snoop_hit from cycle T+1.
- Simultaneous enqueue and dequeue (not full): count is unchanged and both pointers advance.
- Count updates: count +1 on enqueue only, -1 on dequeue only.
- Snoop: snoop_hit = OR over entries of (valid[i] && addr[i] == snoop_addr). It is combinational and includes the head entry even while it is being handed to memory in the current cycle.
- Duplicate addresses: duplicate line addresses are legal. Entries are not merged, and both drain in order.
- Reset mid-operation: all pending entries are discarded and mem_req_valid drops in the next cycle regardless of mem_req_ready.
- full and empty are derived from count only.

Test Plan:
- Enqueue after reset: reset, then enqueue addr 0x100, byteen 0xFFFF, mem_req_ready = 0 -> next cycle mem_req_valid = 1, mem_req_addr = 0x100, count = 1. Outputs stay stable for 5 held cycles. Raise ready -> one transfer, then empty = 1 and count = 0.
- Fill and wrap: enqueue addresses 0x10, 0x11, 0x12, 0x13 -> full = 1, evict_ready = 0. A fifth request is not accepted. Drain all four in order, then enqueue 0x14, 0x15 -> drain order 0x14, 0x15, confirming pointer wrap.
- Simultaneous events at full:
  - With count = 4, assert evict_valid and mem_req_ready together -> only the dequeue occurs, count = 3.
  - With count = 2, assert both -> enqueue and dequeue both occur, count stays 2.
- Clean drop: evict_valid with byteen = 0 at addr 0x20 -> evict_ready = 1, count unchanged, snoop 0x20 gives snoop_hit = 0.
- Snoop: enqueue 0x30 at edge T -> at T, snoop 0x30 gives hit = 0. At T+1, hit = 1. Hit persists while queued, clears the cycle after the 0x30 dequeue handshake. Snoop 0x31 gives hit = 0 throughout.
- Partial mask and reset: enqueue byteen 0x000F with data 0xDEADBEEF in the low word -> mem_req_byteen = 0x000F, data matches. With 3 entries queued, pulse reset for 1 cycle -> count = 0, mem_req_valid = 0, snoop_hit = 0 on all queued addresses.
